// File: rtl/manchester_ctrl_pkg.sv
// Shared types and helpers for the Manchester decoder lock controller.
package manchester_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_CHECK,
        ST_LOCKED,
        ST_FAIL
    } ctrlState_t;

    localparam int REF_W = 4;
    localparam int RUN_W = 8;
    localparam logic [REF_W-1:0] REF_DEFAULT = 4'd8;

    // Synchronised view of one asynchronous input.
    typedef struct packed {
        logic level;
        logic rise;
        logic anyEdge;
    } syncEvt_t;

    // Reference is 1.5x the shortest half-bit run, clipped to the 4-bit range.
    function automatic logic [REF_W-1:0] sat15(input logic [RUN_W-1:0] run);
        logic [RUN_W:0] sum;
        sum = {1'b0, run} + {2'b00, run[RUN_W-1:1]};
        if (sum > 9'd15) return 4'd15;
        return sum[REF_W-1:0];
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser with a third history stage for rise / any-edge detection.
module sync_edge_detect
    import manchester_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     globalResetN,
    input  logic     din,
    output syncEvt_t evt
);

    logic [2:0] stages;

    always_ff @(posedge clk) begin
        if (!globalResetN) stages <= '0;
        else               stages <= {stages[1:0], din};
    end

    assign evt.level   = stages[1];
    assign evt.rise    = stages[1] & ~stages[2];
    assign evt.anyEdge = stages[1] ^ stages[2];

endmodule

// File: rtl/manchester_lock_controller.sv
// Measures the Manchester half-bit period, programs decoder REF, confirms lock
// with a sync word and frames recovered bits into bytes.
module manchester_lock_controller
    import manchester_ctrl_pkg::*;
#(
    parameter int         MEAS_EDGES   = 16,
    parameter logic [7:0] SYNC_WORD    = 8'hA7,
    parameter int         SYNC_TIMEOUT = 64,
    parameter int         MAX_RETRY    = 3,
    parameter int         LOS_CYCLES   = 64
)(
    input  logic             osc,
    input  logic             globalResetN,
    input  logic             enable,
    input  logic             start,
    input  logic             ManchesterCode,
    input  logic             recoveredCLK,
    input  logic             recoveredData,
    output logic [REF_W-1:0] REF,
    output logic             busy,
    output logic             locked,
    output logic             fail,
    output logic             lockLost,
    output logic [7:0]       dataByte,
    output logic             dataValid
);

    localparam int EW = $clog2(MEAS_EDGES + 1);
    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    localparam int LW = $clog2(LOS_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [EW-1:0] EDGE_DONE    = EW'(MEAS_EDGES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(SYNC_TIMEOUT - 1);
    localparam logic [LW-1:0] LOS_LAST     = LW'(LOS_CYCLES - 1);
    localparam logic [LW-1:0] LOS_SAT      = LW'(LOS_CYCLES);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    syncEvt_t codeEvt, clkEvt, dataEvt;

    sync_edge_detect uSyncCode (.clk(osc), .globalResetN(globalResetN), .din(ManchesterCode), .evt(codeEvt));
    sync_edge_detect uSyncClk  (.clk(osc), .globalResetN(globalResetN), .din(recoveredCLK),   .evt(clkEvt));
    sync_edge_detect uSyncData (.clk(osc), .globalResetN(globalResetN), .din(recoveredData),  .evt(dataEvt));

    logic unusedEvt;
    assign unusedEvt = ^{codeEvt.level, codeEvt.rise, clkEvt.level, clkEvt.anyEdge,
                         dataEvt.rise, dataEvt.anyEdge};

    logic codeEdge, clkRise, dataBit;
    assign codeEdge = codeEvt.anyEdge;
    assign clkRise  = clkEvt.rise;
    assign dataBit  = dataEvt.level;

    ctrlState_t       state, stateNext;
    logic [REF_W-1:0] refReg, refSat, refCalc;
    logic [RW-1:0]    retryCnt;
    logic [EW-1:0]    edgeCnt;
    logic [RUN_W-1:0] runCnt, minRun;
    logic [6:0]       shiftReg, byteReg;
    logic [7:0]       shiftNext, byteNext;
    logic [TW-1:0]    bitTimer;
    logic [LW-1:0]    losCnt;
    logic [2:0]       bitCnt;

    logic startReq, measEval, retryPath, failEntry, lossInLock, los;
    logic measStart, checkStart, lockStart;

    assign shiftNext = {shiftReg, dataBit};
    assign byteNext  = {byteReg, dataBit};
    assign refSat    = sat15(minRun);
    assign refCalc   = (refSat == '0) ? REF_W'(1) : refSat;
    assign los       = (state inside {ST_CHECK, ST_LOCKED}) && (losCnt >= LOS_LAST) && !clkRise;

    always_ff @(posedge osc) begin
        if (!globalResetN || !enable) state <= ST_IDLE;
        else                          state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        startReq   = 1'b0;
        measEval   = 1'b0;
        retryPath  = 1'b0;
        lossInLock = 1'b0;
        case (state)
            ST_IDLE, ST_FAIL: begin
                if (start) begin
                    startReq  = 1'b1;
                    stateNext = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (edgeCnt == EDGE_DONE) begin
                    measEval = 1'b1;
                    if (minRun < RUN_W'(2)) retryPath = 1'b1;
                    else                    stateNext = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (clkRise && shiftNext == SYNC_WORD)                 stateNext = ST_LOCKED;
                else if (los || (clkRise && bitTimer == TIMEOUT_LAST)) retryPath = 1'b1;
            end
            ST_LOCKED: begin
                if (los) begin
                    lossInLock = 1'b1;
                    stateNext  = ST_MEASURE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
        if (retryPath) stateNext = (retryCnt < RETRY_MAX) ? ST_MEASURE : ST_FAIL;
    end

    assign failEntry  = retryPath && (retryCnt >= RETRY_MAX);
    assign measStart  = (stateNext == ST_MEASURE) && ((state != ST_MEASURE) || retryPath);
    assign checkStart = (stateNext == ST_CHECK)  && (state != ST_CHECK);
    assign lockStart  = (stateNext == ST_LOCKED) && (state != ST_LOCKED);

    always_ff @(posedge osc) begin
        if (!globalResetN || !enable) begin
            refReg    <= REF_DEFAULT;
            retryCnt  <= '0;
            edgeCnt   <= '0;
            runCnt    <= '0;
            minRun    <= '1;
            shiftReg  <= '0;
            bitTimer  <= '0;
            losCnt    <= '0;
            byteReg   <= '0;
            bitCnt    <= '0;
            dataByte  <= '0;
            dataValid <= 1'b0;
            lockLost  <= 1'b0;
        end else begin
            lockLost  <= lossInLock;
            dataValid <= 1'b0;

            // The first edge of a window only opens a run; later edges close one.
            if (measStart) begin
                edgeCnt <= '0;
                runCnt  <= '0;
                minRun  <= '1;
            end else if (state == ST_MEASURE) begin
                if (codeEdge && edgeCnt != EDGE_DONE) begin
                    edgeCnt <= edgeCnt + 1'b1;
                    runCnt  <= RUN_W'(1);
                    if (edgeCnt != '0 && runCnt < minRun) minRun <= runCnt;
                end else if (runCnt != '1) begin
                    runCnt <= runCnt + 1'b1;
                end
            end

            if (startReq || lossInLock)              retryCnt <= '0;
            else if (retryPath && !failEntry)        retryCnt <= retryCnt + 1'b1;

            if (measEval && !retryPath) refReg <= refCalc;
            else if (failEntry)         refReg <= REF_DEFAULT;

            if (checkStart) begin
                shiftReg <= '0;
                bitTimer <= '0;
            end else if (state == ST_CHECK && clkRise) begin
                shiftReg <= shiftNext[6:0];
                bitTimer <= bitTimer + 1'b1;
            end

            if (!(state inside {ST_CHECK, ST_LOCKED}) || clkRise) losCnt <= '0;
            else if (losCnt != LOS_SAT)                          losCnt <= losCnt + 1'b1;

            // A partial byte left over from a lost lock is dropped on re-entry.
            if (lockStart) begin
                byteReg <= '0;
                bitCnt  <= '0;
            end else if (state == ST_LOCKED && clkRise) begin
                byteReg <= byteNext[6:0];
                bitCnt  <= bitCnt + 1'b1;
                if (bitCnt == 3'd7) begin
                    dataByte  <= byteNext;
                    dataValid <= 1'b1;
                end
            end
        end
    end

    assign REF    = refReg;
    assign busy   = state inside {ST_MEASURE, ST_CHECK, ST_LOCKED};
    assign locked = (state == ST_LOCKED);
    assign fail   = (state == ST_FAIL);

endmodule

// File: tb/tb_manchester_lock_controller.sv
// Directed bench for manchester_lock_controller: measure, lock, framing, LOS, retries, enable.
module tb_manchester_lock_controller;

    logic       osc = 1'b0;
    logic       globalResetN, enable, start, ManchesterCode, recoveredCLK, recoveredData;
    logic [3:0] REF;
    logic       busy, locked, fail, lockLost, dataValid;
    logic [7:0] dataByte;

    int tests = 0;
    int errs = 0;
    int vldCount = 0;
    int vldRun = 0;
    int vldMax = 0;
    int lostCount = 0;
    logic [7:0] caps [4];

    manchester_lock_controller dut (
        .osc(osc), .globalResetN(globalResetN), .enable(enable), .start(start),
        .ManchesterCode(ManchesterCode), .recoveredCLK(recoveredCLK), .recoveredData(recoveredData),
        .REF(REF), .busy(busy), .locked(locked), .fail(fail), .lockLost(lockLost),
        .dataByte(dataByte), .dataValid(dataValid)
    );

    always #5 osc = ~osc;

    always @(negedge osc) begin
        if (dataValid) begin
            if (vldCount < 4) caps[vldCount] = dataByte;
            vldCount++;
            vldRun++;
            if (vldRun > vldMax) vldMax = vldRun;
        end else begin
            vldRun = 0;
        end
        if (lockLost) lostCount++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge osc);
        #1;
    endtask

    task automatic pulseStart;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic edges(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            cyc(half);
            ManchesterCode = ~ManchesterCode;
        end
    endtask

    task automatic sendBit(input logic b);
        recoveredData = b;
        cyc(3);
        recoveredCLK = 1'b1;
        cyc(4);
        recoveredCLK = 1'b0;
        cyc(1);
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) sendBit(v[i]);
    endtask

    task automatic dropEnable(input string tag);
        enable = 1'b0;
        @(posedge osc);
        @(negedge osc);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ref"}, 32'(REF), 32'd8);
        enable = 1'b1;
    endtask

    initial begin
        globalResetN = 1'b0; enable = 1'b1; start = 1'b1;
        ManchesterCode = 1'b0; recoveredCLK = 1'b0; recoveredData = 1'b0;
        cyc(4);
        @(negedge osc);
        chk("rst_ref",    32'(REF),       32'd8);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_locked", 32'(locked),    32'd0);
        chk("rst_fail",   32'(fail),      32'd0);
        chk("rst_valid",  32'(dataValid), 32'd0);
        chk("rst_lost",   32'(lockLost),  32'd0);
        chk("rst_byte",   32'(dataByte),  32'd0);
        start = 1'b0;
        globalResetN = 1'b1;
        cyc(3);

        pulseStart();
        @(negedge osc);
        chk("start_busy", 32'(busy), 32'd1);

        // 6 osc per half-bit: REF = 6 + 3 = 9
        edges(16, 6);
        cyc(6);
        @(negedge osc);
        chk("meas6_ref",    32'(REF),    32'd9);
        chk("meas6_busy",   32'(busy),   32'd1);
        chk("meas6_locked", 32'(locked), 32'd0);
        sendByte(8'hA7);
        cyc(2);
        @(negedge osc);
        chk("sync_locked", 32'(locked), 32'd1);

        sendByte(8'h3C);
        sendByte(8'hFF);
        cyc(3);
        @(negedge osc);
        chk("vld_count", 32'(vldCount), 32'd2);
        chk("byte0",     32'(caps[0]),  32'h3C);
        chk("byte1",     32'(caps[1]),  32'hFF);
        chk("vld_width", 32'(vldMax),   32'd1);
        chk("byte_hold", 32'(dataByte), 32'hFF);

        // Partial byte then recoveredCLK stops
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
        cyc(80);
        @(negedge osc);
        chk("los_pulse",  32'(lostCount), 32'd1);
        chk("los_locked", 32'(locked),    32'd0);
        chk("los_busy",   32'(busy),      32'd1);
        chk("los_novld",  32'(vldCount),  32'd2);
        chk("los_byte",   32'(dataByte),  32'hFF);
        chk("los_ref",    32'(REF),       32'd9);
        dropEnable("dis_meas");

        // 12 osc per half-bit: 12 + 6 = 18 saturates to 15
        cyc(2);
        pulseStart();
        edges(16, 12);
        cyc(6);
        @(negedge osc);
        chk("meas12_ref", 32'(REF), 32'd15);
        pulseStart();
        @(negedge osc);
        chk("chk_start_busy", 32'(busy),   32'd1);
        chk("chk_start_ref",  32'(REF),    32'd15);
        chk("chk_start_lock", 32'(locked), 32'd0);
        dropEnable("dis_check");

        // Line toggling every osc cycle: minRun = 1, initial try plus three retries
        cyc(2);
        pulseStart();
        for (int i = 1; i <= 80; i++) begin
            cyc(1);
            ManchesterCode = ~ManchesterCode;
            if (i == 60) begin
                @(negedge osc);
                chk("retry_nofail", 32'(fail), 32'd0);
                chk("retry_busy",   32'(busy), 32'd1);
            end
        end
        @(negedge osc);
        chk("fail_flag", 32'(fail), 32'd1);
        chk("fail_ref",  32'(REF),  32'd8);
        chk("fail_busy", 32'(busy), 32'd0);

        pulseStart();
        @(negedge osc);
        chk("restart_fail", 32'(fail), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
